countdown_timer: RTL and testbench

- Loadable, synchronous n-bit down-counter that counts from a loaded value down to 0 and issues a one-cycle Done pulse on expiry.
- Complements the free-running up-counter. Typical use: an up-counter's Rollover output drives Tick as a prescaled count enable, and this block times intervals in units of those ticks.
- Start/Stop control with pause/resume; Busy flag reports an active interval.

---
 rtl/countdown_timer_if.sv | 24 ++
 rtl/countdown_timer.sv | 97 +++++++++
 tb/tb_countdown_timer.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/countdown_timer_if.sv
// Control/status bundle for countdown_timer.
// Master drives load/start/stop/tick; slave returns count and status.
interface countdown_timer_if #(
    parameter int n = 4
);
    logic         Load;
    logic [n-1:0] D;
    logic         Start;
    logic         Stop;
    logic         Tick;
    logic [n-1:0] Q;
    logic         Done;
    logic         Busy;

    modport master (
        output Load, D, Start, Stop, Tick,
        input  Q, Done, Busy
    );

    modport slave (
        input  Load, D, Start, Stop, Tick,
        output Q, Done, Busy
    );
endinterface

// File: rtl/countdown_timer.sv
// Loadable n-bit down-counter with start/stop/pause and one-cycle Done.
// Define COUNTDOWN_AUTO_RELOAD_EN for periodic reload on expiry.
module countdown_timer #(
    parameter int n = 4
) (
    input logic              Clock,
    input logic              Reset_n,
    countdown_timer_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    state_t       state, state_nx;
    logic [n-1:0] q, q_nx;
    logic         done, done_nx;
    logic [n-1:0] start_val;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
    logic [n-1:0] rld, rld_nx;
`endif

    // A same-cycle Load supplies the start value directly.
    assign start_val = bus.Load ? bus.D : q;

    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            state <= IDLE;
            q     <= '0;
            done  <= 1'b0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
            rld   <= '0;
`endif
        end else begin
            state <= state_nx;
            q     <= q_nx;
            done  <= done_nx;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
            rld   <= rld_nx;
`endif
        end
    end

    always_comb begin
        state_nx = state;
        q_nx     = q;
        done_nx  = 1'b0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
        rld_nx   = rld;
`endif
        unique case (state)
            IDLE, PAUSE: begin
                if (bus.Load) begin
                    q_nx = bus.D;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                    rld_nx = bus.D;
`endif
                end
                if (bus.Start) begin
                    if (start_val != '0) begin
                        state_nx = RUN;
                    end else begin
                        done_nx  = 1'b1;
                        state_nx = IDLE;
                    end
                end
            end
            RUN: begin
                if (bus.Stop) begin
                    state_nx = PAUSE;
                end else if (bus.Tick) begin
                    if (q > n'(1)) begin
                        q_nx = q - n'(1);
                    end else begin
                        done_nx = 1'b1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                        q_nx = rld;
`else
                        q_nx     = '0;
                        state_nx = IDLE;
`endif
                    end
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    assign bus.Q    = q;
    assign bus.Done = done;
    assign bus.Busy = (state == RUN) || (state == PAUSE);

endmodule

// File: tb/tb_countdown_timer.sv
// Directed self-checking bench for countdown_timer.
// Expiry tests follow COUNTDOWN_AUTO_RELOAD_EN when defined.
module tb_countdown_timer;

    logic Clock;
    logic Reset_n;
    int   checks;
    int   errors;

    countdown_timer_if #(.n(4)) bus ();

    countdown_timer #(.n(4)) dut (
        .Clock   (Clock),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic idle_in();
        bus.Load  = 1'b0;
        bus.D     = 4'd0;
        bus.Start = 1'b0;
        bus.Stop  = 1'b0;
        bus.Tick  = 1'b0;
    endtask

    task automatic do_reset();
        idle_in();
        Reset_n = 1'b0;
        step();
        Reset_n = 1'b1;
    endtask

    task automatic test_reset();
        idle_in();
        bus.Start = 1'b1;
        bus.Load  = 1'b1;
        bus.D     = 4'd7;
        Reset_n   = 1'b0;
        step();
        checks++;
        if (bus.Q !== 4'd0) begin
            errors++;
            $display("FAIL reset_q got %0d want 0", bus.Q);
        end
        checks++;
        if (bus.Done !== 1'b0) begin
            errors++;
            $display("FAIL reset_done got %b want 0", bus.Done);
        end
        checks++;
        if (bus.Busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy got %b want 0", bus.Busy);
        end
        Reset_n = 1'b1;
        idle_in();
    endtask

    task automatic test_basic();
        logic [3:0] eq [4] = '{4'd3, 4'd2, 4'd1, 4'd0};
        logic       ed [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        logic       eb [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        do_reset();
        bus.Load  = 1'b1;
        bus.D     = 4'd3;
        bus.Start = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            bus.Load  = 1'b0;
            bus.Start = 1'b0;
            bus.Tick  = 1'b1;
            checks++;
            if (bus.Q !== eq[i] || bus.Done !== ed[i]
                || bus.Busy !== eb[i]) begin
                errors++;
                $display("FAIL basic[%0d] got q=%0d d=%b b=%b want q=%0d d=%b b=%b",
                         i, bus.Q, bus.Done, bus.Busy, eq[i], ed[i], eb[i]);
            end
        end
        step();
        checks++;
        if (bus.Q !== 4'd0 || bus.Done !== 1'b0 || bus.Busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_after got q=%0d d=%b b=%b want q=0 d=0 b=0",
                     bus.Q, bus.Done, bus.Busy);
        end
        idle_in();
    endtask

    task automatic test_prescale();
        logic [3:0] wq;
        logic       wd;
        do_reset();
        bus.Load  = 1'b1;
        bus.D     = 4'd2;
        bus.Start = 1'b1;
        step();
        bus.Load  = 1'b0;
        bus.Start = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            bus.Tick = (i % 4 == 0);
            step();
            wq = (i >= 8) ? 4'd0 : 4'(2 - i / 4);
            wd = (i == 8);
            checks++;
            if (bus.Q !== wq || bus.Done !== wd) begin
                errors++;
                $display("FAIL prescale[%0d] got q=%0d d=%b want q=%0d d=%b",
                         i, bus.Q, bus.Done, wq, wd);
            end
        end
        idle_in();
    endtask

    task automatic test_pause();
        do_reset();
        bus.Load  = 1'b1;
        bus.D     = 4'd7;
        bus.Start = 1'b1;
        step();
        bus.Load  = 1'b0;
        bus.Start = 1'b0;
        bus.Tick  = 1'b1;
        step();
        step();
        bus.Stop = 1'b1;
        step();
        checks++;
        if (bus.Q !== 4'd5 || bus.Busy !== 1'b1 || bus.Done !== 1'b0) begin
            errors++;
            $display("FAIL stop_tick got q=%0d b=%b d=%b want q=5 b=1 d=0",
                     bus.Q, bus.Busy, bus.Done);
        end
        bus.Stop = 1'b0;
        step();
        checks++;
        if (bus.Q !== 4'd5) begin
            errors++;
            $display("FAIL pause_tick got q=%0d want 5", bus.Q);
        end
        bus.Tick = 1'b0;
        bus.Load = 1'b1;
        bus.D    = 4'd9;
        step();
        bus.Load = 1'b0;
        checks++;
        if (bus.Q !== 4'd9 || bus.Busy !== 1'b1) begin
            errors++;
            $display("FAIL pause_load got q=%0d b=%b want q=9 b=1",
                     bus.Q, bus.Busy);
        end
        bus.Start = 1'b1;
        step();
        bus.Start = 1'b0;
        bus.Tick  = 1'b1;
        step();
        checks++;
        if (bus.Q !== 4'd8) begin
            errors++;
            $display("FAIL resume_load got q=%0d want 8", bus.Q);
        end
        bus.Tick = 1'b0;
        bus.Stop = 1'b1;
        step();
        bus.Stop  = 1'b0;
        bus.Start = 1'b1;
        step();
        bus.Start = 1'b0;
        bus.Tick  = 1'b1;
        step();
        checks++;
        if (bus.Q !== 4'd7 || bus.Busy !== 1'b1) begin
            errors++;
            $display("FAIL resume_held got q=%0d b=%b want q=7 b=1",
                     bus.Q, bus.Busy);
        end
        bus.Tick = 1'b0;
        bus.Stop = 1'b1;
        step();
        bus.Stop  = 1'b0;
        bus.Load  = 1'b1;
        bus.D     = 4'd0;
        bus.Start = 1'b1;
        step();
        checks++;
        if (bus.Q !== 4'd0 || bus.Done !== 1'b1 || bus.Busy !== 1'b0) begin
            errors++;
            $display("FAIL pause_zero got q=%0d d=%b b=%b want q=0 d=1 b=0",
                     bus.Q, bus.Done, bus.Busy);
        end
        idle_in();
    endtask

    task automatic test_zero_start();
        do_reset();
        bus.Start = 1'b1;
        step();
        checks++;
        if (bus.Q !== 4'd0 || bus.Done !== 1'b1 || bus.Busy !== 1'b0) begin
            errors++;
            $display("FAIL zero_start got q=%0d d=%b b=%b want q=0 d=1 b=0",
                     bus.Q, bus.Done, bus.Busy);
        end
        bus.Start = 1'b0;
        step();
        checks++;
        if (bus.Done !== 1'b0 || bus.Busy !== 1'b0) begin
            errors++;
            $display("FAIL zero_pulse got d=%b b=%b want d=0 b=0",
                     bus.Done, bus.Busy);
        end
        bus.Load = 1'b1;
        bus.D    = 4'd5;
        step();
        bus.D     = 4'd0;
        bus.Start = 1'b1;
        step();
        checks++;
        if (bus.Q !== 4'd0 || bus.Done !== 1'b1 || bus.Busy !== 1'b0) begin
            errors++;
            $display("FAIL zero_load got q=%0d d=%b b=%b want q=0 d=1 b=0",
                     bus.Q, bus.Done, bus.Busy);
        end
        idle_in();
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus.Load  = 1'b1;
        bus.D     = 4'd8;
        bus.Start = 1'b1;
        step();
        bus.Load  = 1'b0;
        bus.Start = 1'b0;
        bus.Tick  = 1'b1;
        step();
        step();
        checks++;
        if (bus.Q !== 4'd6) begin
            errors++;
            $display("FAIL mid_pre got q=%0d want 6", bus.Q);
        end
        Reset_n = 1'b0;
        step();
        checks++;
        if (bus.Q !== 4'd0 || bus.Busy !== 1'b0 || bus.Done !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset got q=%0d b=%b d=%b want q=0 b=0 d=0",
                     bus.Q, bus.Busy, bus.Done);
        end
        Reset_n = 1'b1;
        step();
        checks++;
        if (bus.Done !== 1'b0 || bus.Busy !== 1'b0 || bus.Q !== 4'd0) begin
            errors++;
            $display("FAIL mid_release got q=%0d b=%b d=%b want q=0 b=0 d=0",
                     bus.Q, bus.Busy, bus.Done);
        end
        idle_in();
    endtask

`ifdef COUNTDOWN_AUTO_RELOAD_EN
    task automatic test_auto();
        logic [3:0] eq [7] = '{4'd3, 4'd2, 4'd1, 4'd3, 4'd2, 4'd1, 4'd3};
        logic       ed [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        do_reset();
        bus.Load  = 1'b1;
        bus.D     = 4'd3;
        bus.Start = 1'b1;
        for (int i = 0; i < 7; i++) begin
            step();
            bus.Load  = 1'b0;
            bus.Start = 1'b0;
            bus.Tick  = 1'b1;
            checks++;
            if (bus.Q !== eq[i] || bus.Done !== ed[i] || bus.Busy !== 1'b1) begin
                errors++;
                $display("FAIL auto[%0d] got q=%0d d=%b b=%b want q=%0d d=%b b=1",
                         i, bus.Q, bus.Done, bus.Busy, eq[i], ed[i]);
            end
        end
        step();
        step();
        bus.Stop = 1'b1;
        step();
        checks++;
        if (bus.Q !== 4'd1 || bus.Done !== 1'b0 || bus.Busy !== 1'b1) begin
            errors++;
            $display("FAIL auto_stop got q=%0d d=%b b=%b want q=1 d=0 b=1",
                     bus.Q, bus.Done, bus.Busy);
        end
        idle_in();
    endtask
`endif

    initial begin
        checks  = 0;
        errors  = 0;
        Reset_n = 1'b1;
        idle_in();
        test_reset();
`ifdef COUNTDOWN_AUTO_RELOAD_EN
        test_auto();
`else
        test_basic();
        test_prescale();
        test_reset_mid();
`endif
        test_pause();
        test_zero_start();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
